// File: rtl/gate_array_pkg.sv
// gate_array_pkg: op encoding and gate delays (in inverter units) for gate_array.
package gate_array_pkg;
  typedef enum logic [1:0] {OP_INV, OP_NAND2, OP_NOR2, OP_XOR2} op_e;
  localparam int UNITS_INV   = 1;
  localparam int UNITS_NAND2 = 2;
  localparam int UNITS_NOR2  = 2;
  localparam int UNITS_XOR2  = 4;
  localparam int UNITS_MAX   = 4;
  function automatic int op_units(op_e op);
    return op == OP_INV ? UNITS_INV : op == OP_NAND2 ? UNITS_NAND2 :
           op == OP_NOR2 ? UNITS_NOR2 : UNITS_XOR2;
  endfunction
endpackage

// File: rtl/gate_array_popcount.sv
// gate_array_popcount: population count of a WIDTH-bit vector.
//   a_i   : input vector
//   cnt_o : number of set bits in a_i
module gate_array_popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]             a_i,
  output logic [$clog2(WIDTH+1)-1:0]   cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) cnt_o = cnt_o + $bits(cnt_o)'(a_i[i]);
  end
endmodule

// File: rtl/gate_array.sv
// gate_array: WIDTH-lane INV/NAND2/NOR2/XOR2 array with op-dependent pipeline latency.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake; in_ready depends on in_op and ordering state only
//   in_op, in_a, in_b     : op select and operands
//   out_valid, out_data   : one-cycle result pulse; out_data holds between pulses
//   cnt_clr, toggle_cnt   : result toggle counter, present only with GATE_ARRAY_TOGGLE_CNT_EN
module gate_array
  import gate_array_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int UNIT_DELAY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef GATE_ARRAY_TOGGLE_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);
  localparam int MAXL = UNITS_MAX * UNIT_DELAY;
  localparam int LW   = $clog2(MAXL + 1);
  if (UNIT_DELAY < 1 || CNT_W < 1) begin : g_bad_param
    $error("gate_array: UNIT_DELAY and CNT_W must be at least 1");
  end
  op_e              op;
  logic [LW-1:0]    lat, rem_q, rem_d;
  logic [WIDTH-1:0] res, out_data_q, out_data_d;
  logic             acc;
  // Slot j holds a result that becomes visible j edges from now; slot 0 is the output.
  logic [MAXL-1:0]  v_q, v_d;
  logic [WIDTH-1:0] d_q [MAXL];
  logic [WIDTH-1:0] d_d [MAXL];
  always_comb begin
    op  = op_e'(in_op);
    res = op == OP_INV ? ~in_a : op == OP_NAND2 ? ~(in_a & in_b) :
          op == OP_NOR2 ? ~(in_a | in_b) : in_a ^ in_b;
    lat = LW'(op_units(op) * UNIT_DELAY);
  end
  // Only ordering state gates acceptance, so no in_valid -> in_ready path exists.
  assign in_ready = rst_n && (lat > rem_q);
  assign acc      = in_valid && in_ready;
  always_comb begin
    v_d = {1'b0, v_q[MAXL-1:1]};
    for (int j = 0; j < MAXL - 1; j++) d_d[j] = d_q[j+1];
    d_d[MAXL-1] = '0;
    for (int j = 0; j < MAXL; j++) begin
      if (acc && lat == LW'(j + 1)) begin
        v_d[j] = 1'b1;
        d_d[j] = res;
      end
    end
    out_data_d = v_d[0] ? d_d[0] : out_data_q;
    rem_d      = acc ? lat - 1'b1 : rem_q == '0 ? '0 : rem_q - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q        <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
    end else begin
      v_q        <= v_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
    end
  end
  always_ff @(posedge clk) d_q <= d_d;
  assign out_valid = v_q[0];
  assign out_data  = out_data_q;
`ifdef GATE_ARRAY_TOGGLE_CNT_EN
  logic [$clog2(WIDTH+1)-1:0] pc;
  logic [CNT_W:0]             sum;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  gate_array_popcount #(.WIDTH(WIDTH)) u_popcount (
    .a_i   (d_d[0] ^ out_data_q),
    .cnt_o (pc)
  );
  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W + 1)'(pc);
    cnt_d = cnt_clr ? '0 : v_d[0] ? (sum[CNT_W] ? '1 : sum[CNT_W-1:0]) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign toggle_cnt = cnt_q;
`endif
endmodule
